io_msg_ctl: RTL and testbench

Parametrised UART-side traffic controller sitting between the UART receiver/transmitter pair and the board switches. It generalises the echo/hello controller: configurable data width, a loadable message memory, a programmable repeat period, and a third mode that buffers a received line and echoes it back whole. All transmit traffic goes through a single `dout`/`tx_en` handshake.

---
 rtl/io_msg_ctl.sv | 279 +++++++++++++++++++++++++++
 tb/tb_io_msg_ctl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_msg_ctl.sv
// io_msg_ctl: UART-side traffic controller.
// Three traffic sources share one transmit strobe:
//   - echo: each received character is sent straight back through a
//     one-entry holding register;
//   - periodic message: a loadable MSG_LEN-character memory is sent once
//     per PERIOD cycles;
//   - line echo: received characters are buffered until CR (or a full
//     buffer), then the whole line is sent back, followed by LF when the
//     line ended on CR.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode[1:0]             0 echo, 1 periodic message, 2 line echo, 3 idle
//   din, d_rdy            receiver character and data-ready level
//   tx_rdy                transmitter idle
//   msg_we/addr/wdata     message memory write port
//   ovf_clr               clears the sticky overflow flag
//   dout, tx_en           character to transmit and its one-cycle strobe
//   busy                  message or line transfer in progress
//   ovf                   a received character was dropped
module io_msg_ctl #(
   parameter int DATA_W    = 8,
   parameter int MSG_LEN   = 15,
   parameter int PERIOD    = 100000,
   parameter int BUF_DEPTH = 16,
   localparam int AW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] din,
   input  logic              d_rdy,
   input  logic              tx_rdy,
   input  logic              msg_we,
   input  logic [AW-1:0]     msg_addr,
   input  logic [DATA_W-1:0] msg_wdata,
   input  logic              ovf_clr,
   output logic [DATA_W-1:0] dout,
   output logic              tx_en,
   output logic              busy,
   output logic              ovf
);

   localparam int IW = $clog2(MSG_LEN + 1);   // read index also holds MSG_LEN (done marker)
   localparam int TW = $clog2(PERIOD);
   localparam int BW = $clog2(BUF_DEPTH);
   localparam int CW = BW + 1;
   localparam logic [DATA_W-1:0] CR_C = DATA_W'(8'h0D);
   localparam logic [DATA_W-1:0] LF_C = DATA_W'(8'h0A);

   typedef enum logic [2:0] {
      S_IDLE         = 3'd0,
      S_ECHO         = 3'd1,
      S_MSG_WAIT     = 3'd2,
      S_MSG_SEND     = 3'd3,
      S_LINE_COLLECT = 3'd4,
      S_LINE_SEND    = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic              d_rdy_q;
   logic              rx_new_q, rx_new_d;
   logic              tx_en_q, tx_en_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              busy_q, busy_d;
   logic              ovf_q, ovf_d;
   logic              hold_full_q, hold_full_d;
   logic [DATA_W-1:0] hold_data_q, hold_data_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     rd_q, rd_d;
   logic              lf_q, lf_d;

   logic              send_ok_s;
   logic              mode_match_s;
   logic              tc_s;
   logic              ovf_set_s;
   logic              buf_we_s;
   logic [CW-1:0]     total_s;
   logic [DATA_W-1:0] msg_rd_s;
   logic [DATA_W-1:0] buf_rd_s;

   logic [DATA_W-1:0] msg_mem  [MSG_LEN];
   logic [DATA_W-1:0] line_buf [BUF_DEPTH];

   // The guard is simply the previous pulse: no strobe two cycles running.
   assign send_ok_s = tx_rdy & ~tx_en_q;
   assign tc_s      = (timer_q == TW'(PERIOD - 1));
   assign total_s   = cnt_q + {{(CW-1){1'b0}}, lf_q};
   assign msg_rd_s  = msg_mem[idx_q[AW-1:0]];
   assign buf_rd_s  = line_buf[rd_q[BW-1:0]];
   assign rx_new_d  = d_rdy & ~d_rdy_q;

   // Message memory write port; contents survive reset, out-of-range writes dropped.
   always_ff @(posedge clk) begin
      if (msg_we && ({1'b0, msg_addr} < (AW+1)'(MSG_LEN))) begin
         msg_mem[msg_addr] <= msg_wdata;
      end
   end

   // Line buffer write port, addressed by the current character count.
   always_ff @(posedge clk) begin
      if (buf_we_s) begin
         line_buf[cnt_q[BW-1:0]] <= din;
      end
   end

   // Next-state, transmit and bookkeeping logic for all modes.
   always_comb begin
      state_d     = state_q;
      tx_en_d     = 1'b0;
      dout_d      = dout_q;
      busy_d      = busy_q;
      hold_full_d = hold_full_q;
      hold_data_d = hold_data_q;
      timer_d     = timer_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      lf_d        = lf_q;
      ovf_set_s   = 1'b0;
      buf_we_s    = 1'b0;

      case (state_q)
         S_ECHO:                     mode_match_s = (mode == 2'd0);
         S_MSG_WAIT, S_MSG_SEND:     mode_match_s = (mode == 2'd1);
         S_LINE_COLLECT, S_LINE_SEND: mode_match_s = (mode == 2'd2);
         default:                    mode_match_s = 1'b1;
      endcase

      if (!mode_match_s) begin
         // Abandon whatever was in progress; a strobe already issued stands.
         state_d     = S_IDLE;
         hold_full_d = 1'b0;
         cnt_d       = {CW{1'b0}};
         lf_d        = 1'b0;
         timer_d     = {TW{1'b0}};
         busy_d      = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               case (mode)
                  2'd0:    state_d = S_ECHO;
                  2'd1:    state_d = S_MSG_WAIT;
                  2'd2:    state_d = S_LINE_COLLECT;
                  default: state_d = S_IDLE;
               endcase
            end
            S_ECHO: begin
               if (hold_full_q && send_ok_s) begin
                  tx_en_d     = 1'b1;
                  dout_d      = hold_data_q;
                  hold_full_d = 1'b0;
               end else begin
                  hold_full_d = hold_full_q;
               end
               // A character arriving as the held one leaves is accepted.
               if (rx_new_q) begin
                  if (hold_full_q && !send_ok_s) begin
                     ovf_set_s = 1'b1;
                  end else begin
                     hold_full_d = 1'b1;
                     hold_data_d = din;
                  end
               end else begin
                  hold_data_d = hold_data_q;
               end
            end
            S_MSG_WAIT: begin
               timer_d = tc_s ? {TW{1'b0}} : timer_q + {{(TW-1){1'b0}}, 1'b1};
               if (tc_s) begin
                  state_d = S_MSG_SEND;
                  busy_d  = 1'b1;
                  idx_d   = {IW{1'b0}};
               end else begin
                  state_d = S_MSG_WAIT;
               end
            end
            S_MSG_SEND: begin
               // Timer keeps running; a terminal count seen here is skipped.
               timer_d = tc_s ? {TW{1'b0}} : timer_q + {{(TW-1){1'b0}}, 1'b1};
               if (idx_q == IW'(MSG_LEN)) begin
                  // One cycle after the last strobe.
                  busy_d  = 1'b0;
                  state_d = S_MSG_WAIT;
               end else if (send_ok_s) begin
                  tx_en_d = 1'b1;
                  dout_d  = msg_rd_s;
                  idx_d   = idx_q + {{(IW-1){1'b0}}, 1'b1};
               end else begin
                  idx_d = idx_q;
               end
            end
            S_LINE_COLLECT: begin
               if (rx_new_q) begin
                  buf_we_s = 1'b1;
                  cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                  if ((din == CR_C) || (cnt_q == CW'(BUF_DEPTH - 1))) begin
                     state_d = S_LINE_SEND;
                     busy_d  = 1'b1;
                     rd_d    = {CW{1'b0}};
                     lf_d    = (din == CR_C);
                  end else begin
                     state_d = S_LINE_COLLECT;
                  end
               end else begin
                  state_d = S_LINE_COLLECT;
               end
            end
            S_LINE_SEND: begin
               if (rx_new_q) begin
                  ovf_set_s = 1'b1;
               end else begin
                  ovf_set_s = 1'b0;
               end
               // Stored characters first, then the optional LF as one extra slot.
               if (rd_q == total_s) begin
                  cnt_d   = {CW{1'b0}};
                  lf_d    = 1'b0;
                  busy_d  = 1'b0;
                  state_d = S_LINE_COLLECT;
               end else if (send_ok_s) begin
                  tx_en_d = 1'b1;
                  dout_d  = (rd_q < cnt_q) ? buf_rd_s : LF_C;
                  rd_d    = rd_q + {{(CW-1){1'b0}}, 1'b1};
               end else begin
                  rd_d = rd_q;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      ovf_d = ovf_set_s | (ovf_q & ~ovf_clr);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         d_rdy_q     <= 1'b0;
         rx_new_q    <= 1'b0;
         tx_en_q     <= 1'b0;
         dout_q      <= {DATA_W{1'b0}};
         busy_q      <= 1'b0;
         ovf_q       <= 1'b0;
         hold_full_q <= 1'b0;
         hold_data_q <= {DATA_W{1'b0}};
         timer_q     <= {TW{1'b0}};
         idx_q       <= {IW{1'b0}};
         cnt_q       <= {CW{1'b0}};
         rd_q        <= {CW{1'b0}};
         lf_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         d_rdy_q     <= d_rdy;
         rx_new_q    <= rx_new_d;
         tx_en_q     <= tx_en_d;
         dout_q      <= dout_d;
         busy_q      <= busy_d;
         ovf_q       <= ovf_d;
         hold_full_q <= hold_full_d;
         hold_data_q <= hold_data_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         lf_q        <= lf_d;
      end
   end

   assign dout  = dout_q;
   assign tx_en = tx_en_q;
   assign busy  = busy_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_io_msg_ctl.sv
// Scoreboard bench for io_msg_ctl: stimulus pushes expected transmit
// characters into a queue; a negedge monitor pops one per tx_en pulse.
// The transmitter is modelled as busy for bl cycles after each pulse.
module tb_io_msg_ctl;

   localparam int DATA_W    = 8;
   localparam int MSG_LEN   = 15;
   localparam int PERIOD    = 64;
   localparam int BUF_DEPTH = 16;
   localparam int AW        = $clog2(MSG_LEN);

   logic              clk = 1'b0;
   logic              rst_n;
   logic [1:0]        mode;
   logic [DATA_W-1:0] din;
   logic              d_rdy;
   logic              tx_rdy;
   logic              msg_we;
   logic [AW-1:0]     msg_addr;
   logic [DATA_W-1:0] msg_wdata;
   logic              ovf_clr;
   logic [DATA_W-1:0] dout;
   logic              tx_en;
   logic              busy;
   logic              ovf;

   int tests = 0;
   int fails = 0;
   int pulses = 0;
   int cyc = 0;
   int bl = 0;
   int busy_cnt = 0;
   logic tx_rdy_en = 1'b1;
   logic busy_prev = 1'b0;
   logic [7:0] mon_exp;
   logic [7:0] exp_q [$];
   int rises [$];
   string msg = "Hello, world!\r\n";

   io_msg_ctl #(.DATA_W(DATA_W), .MSG_LEN(MSG_LEN), .PERIOD(PERIOD), .BUF_DEPTH(BUF_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .din(din), .d_rdy(d_rdy), .tx_rdy(tx_rdy),
      .msg_we(msg_we), .msg_addr(msg_addr), .msg_wdata(msg_wdata), .ovf_clr(ovf_clr),
      .dout(dout), .tx_en(tx_en), .busy(busy), .ovf(ovf));

   always #5 clk = ~clk;

   assign tx_rdy = tx_rdy_en && (busy_cnt == 0);

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Monitor plus transmitter-busy model.
   always @(negedge clk) begin
      if (rst_n && tx_en) begin
         pulses++;
         if (mode == 2'd1 || mode == 2'd2) check("busy_during_tx", {31'd0, busy}, 32'd1);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_tx: got dout %0h, expected no pulse (t=%0t)", dout, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            check("tx_data", {24'd0, dout}, {24'd0, mon_exp});
         end
      end
      if (busy && !busy_prev) rises.push_back(cyc);
      busy_prev = busy;
      if (tx_en) busy_cnt = bl;
      else if (busy_cnt > 0) busy_cnt--;
   end

   task automatic send_char(input logic [7:0] c);
      @(negedge clk);
      din = c;
      d_rdy = 1'b1;
      repeat (3) @(negedge clk);
      d_rdy = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_drain(input string nm, input int max_cyc);
      int n = 0;
      while (exp_q.size() != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      repeat (6) @(negedge clk);
      check(nm, exp_q.size(), 32'd0);
   endtask

   task automatic wait_busy(input string nm, input int max_cyc);
      int n = 0;
      while (!busy && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check(nm, {31'd0, busy}, 32'd1);
   endtask

   task automatic push_msg();
      for (int i = 0; i < MSG_LEN; i++) exp_q.push_back(msg[i]);
   endtask

   task automatic periodic(input int blen);
      int n = 0;
      int fall_off;
      int spacing;
      bl = blen;
      rises.delete();
      push_msg();
      push_msg();
      @(negedge clk);
      mode = 2'd1;
      while ((rises.size() < 2 || exp_q.size() != 0) && n < 800) begin
         @(negedge clk);
         n++;
      end
      mode = 2'd3;
      check("periodic_drain", exp_q.size(), 32'd0);
      check("periodic_starts", (rises.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
      // A start is skipped whenever the transfer still runs at the next terminal count.
      fall_off = (MSG_LEN - 1) * (blen + 1) + 2;
      spacing  = PERIOD * ((fall_off / PERIOD) + 1);
      if (rises.size() >= 2) check("periodic_spacing", rises[1] - rises[0], spacing);
      repeat (4) @(negedge clk);
      check("periodic_busy_off", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n0;
      int len;
      logic [7:0] c;
      rst_n = 1'b0; mode = 2'd3; din = 8'd0; d_rdy = 1'b0;
      msg_we = 1'b0; msg_addr = '0; msg_wdata = 8'd0; ovf_clr = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_dout", {24'd0, dout}, 32'd0);
      check("rst_tx_en", {31'd0, tx_en}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_ovf", {31'd0, ovf}, 32'd0);

      for (int i = 0; i < MSG_LEN; i++) begin
         @(negedge clk);
         msg_we = 1'b1; msg_addr = AW'(i); msg_wdata = msg[i];
      end
      @(negedge clk);
      msg_addr = AW'(15); msg_wdata = 8'h5A;   // out of range, ignored
      @(negedge clk);
      msg_we = 1'b0;

      // Echo with exact latency.
      mode = 2'd0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         c = (k == 0) ? 8'h41 : 8'h42;
         @(negedge clk);
         din = c; d_rdy = 1'b1;
         exp_q.push_back(c);
         @(posedge clk); @(posedge clk); #1;
         check("echo_not_early", {31'd0, tx_en}, 32'd0);
         @(posedge clk); #1;
         check("echo_latency_tx_en", {31'd0, tx_en}, 32'd1);
         check("echo_latency_dout", {24'd0, dout}, {24'd0, c});
         @(negedge clk);
         d_rdy = 1'b0;
         repeat (4) @(negedge clk);
      end
      for (int k = 0; k < 6; k++) begin
         bl = $urandom_range(0, 2);
         c = 8'($urandom_range(0, 255));
         exp_q.push_back(c);
         send_char(c);
      end
      wait_drain("echo_drain", 50);
      check("echo_no_ovf", {31'd0, ovf}, 32'd0);

      // Echo overflow: second character dropped, set wins over clear.
      bl = 0;
      tx_rdy_en = 1'b0;
      exp_q.push_back(8'h31);
      send_char(8'h31);
      @(negedge clk);
      din = 8'h32; d_rdy = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ovf_clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ovf_clr = 1'b0;
      check("ovf_set_over_clr", {31'd0, ovf}, 32'd1);
      d_rdy = 1'b0;
      repeat (4) @(negedge clk);
      tx_rdy_en = 1'b1;
      wait_drain("ovf_drain", 20);
      check("ovf_sticky", {31'd0, ovf}, 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      #1;
      check("ovf_cleared", {31'd0, ovf}, 32'd0);

      // Periodic message: fits the period, then overruns it.
      mode = 2'd3;
      repeat (3) @(negedge clk);
      periodic(3);
      periodic(4);

      // Reset in the middle of a message.
      bl = 0;
      push_msg();
      @(negedge clk);
      mode = 2'd1;
      wait_busy("reset_wait_busy", 200);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst2_dout", {24'd0, dout}, 32'd0);
      check("rst2_tx_en", {31'd0, tx_en}, 32'd0);
      check("rst2_busy", {31'd0, busy}, 32'd0);
      check("rst2_ovf", {31'd0, ovf}, 32'd0);
      n0 = pulses;
      repeat (PERIOD - 1) @(negedge clk);
      check("rst2_quiet", pulses - n0, 32'd0);
      mode = 2'd3;
      repeat (3) @(negedge clk);

      // Line echo.
      mode = 2'd2;
      repeat (3) @(negedge clk);
      exp_q.push_back(8'h61); exp_q.push_back(8'h62);
      exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
      send_char(8'h61);
      send_char(8'h62);
      send_char(8'h0D);
      wait_drain("line_cr_drain", 40);
      check("line_busy_off", {31'd0, busy}, 32'd0);
      for (int i = 0; i < BUF_DEPTH; i++) exp_q.push_back(8'h78);
      for (int i = 0; i < BUF_DEPTH; i++) send_char(8'h78);
      send_char(8'h71);   // arrives mid-transfer and is dropped
      wait_drain("line_full_drain", 100);
      repeat (6) @(negedge clk);
      check("line_drop_ovf", {31'd0, ovf}, 32'd1);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bl = $urandom_range(0, 3);
         len = $urandom_range(1, 5);
         for (int i = 0; i < len; i++) begin
            c = 8'($urandom_range(32, 126));
            exp_q.push_back(c);
            send_char(c);
         end
         exp_q.push_back(8'h0D);
         exp_q.push_back(8'h0A);
         send_char(8'h0D);
         wait_drain("line_rand_drain", 60);
         check("line_rand_busy_off", {31'd0, busy}, 32'd0);
      end
      check("line_no_ovf", {31'd0, ovf}, 32'd0);

      // Mode change 1 -> 0 in the middle of a message.
      mode = 2'd3;
      repeat (3) @(negedge clk);
      bl = 3;
      push_msg();
      @(negedge clk);
      mode = 2'd1;
      wait_busy("switch_wait_busy", 200);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2;
      n0 = pulses;
      mode = 2'd0;
      repeat (10) @(negedge clk);
      check("switch_at_most_one", (pulses - n0 <= 1) ? 32'd1 : 32'd0, 32'd1);
      check("switch_busy_off", {31'd0, busy}, 32'd0);
      exp_q.delete();
      bl = 0;
      exp_q.push_back(8'h55);
      send_char(8'h55);
      wait_drain("switch_echo", 20);
      check("switch_no_ovf", {31'd0, ovf}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
